// File: rtl/qdr_cal_sequencer_if.sv
// Calibration bus between the QDR calibration sequencer and the PHY/memory datapath.
interface qdr_cal_sequencer_if #(
    parameter int DATA_WIDTH = 36,
    parameter int ADDR_WIDTH = 21
) ();
    logic                  cal_wr_en;
    logic                  cal_rd_en;
    logic [ADDR_WIDTH-1:0] cal_addr;
    logic [DATA_WIDTH-1:0] cal_wr_data;
    logic                  cal_rd_valid;
    logic [DATA_WIDTH-1:0] cal_rd_data;

    modport master (
        output cal_wr_en, cal_rd_en, cal_addr, cal_wr_data,
        input  cal_rd_valid, cal_rd_data
    );

    modport slave (
        input  cal_wr_en, cal_rd_en, cal_addr, cal_wr_data,
        output cal_rd_valid, cal_rd_data
    );
endinterface

// File: rtl/qdr_cal_sequencer.sv
// QDR PHY power-up/recalibration sequencer: DLL reset, lock wait, pattern write, read-tap sweep.
// phy_rdy rises RST_CYCLES+2*CAL_WORDS+L+1 edges after the last edge sampling reset, L = edges from cal_rd_en rise to its sampled return.
module qdr_cal_sequencer #(
    parameter int DATA_WIDTH    = 36,
    parameter int ADDR_WIDTH    = 21,
    parameter int CAL_WORDS     = 4,
    parameter int TAP_WIDTH     = 6,
    parameter int RST_CYCLES    = 64,
    parameter int LOCK_TIMEOUT  = 65536,
    parameter int RD_TIMEOUT    = 64,
    parameter int SETTLE_CYCLES = 16
) (
    input  logic                 qdr_clk,
    input  logic                 qdr_rst_n,
    input  logic                 qdr_reset,
    input  logic                 dll_locked,
    output logic                 phy_dll_rst,
    output logic                 dly_rst,
    output logic                 dly_inc,
    output logic [TAP_WIDTH-1:0] cal_tap,
    output logic                 phy_rdy,
    output logic                 cal_fail,
    qdr_cal_sequencer_if.master  cal
);

    localparam int CNT_A   = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int CNT_B   = (RD_TIMEOUT > SETTLE_CYCLES) ? RD_TIMEOUT : SETTLE_CYCLES;
    localparam int CNT_MAX = (CNT_A > CNT_B) ? CNT_A : CNT_B;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int KW      = $clog2(CAL_WORDS + 1);
    localparam logic [TAP_WIDTH-1:0] TAP_LAST = {TAP_WIDTH{1'b1}};

    typedef enum logic [3:0] {
        ST_RST       = 4'd0,
        ST_LOCK_WAIT = 4'd1,
        ST_WRITE     = 4'd2,
        ST_READ      = 4'd3,
        ST_CHECK     = 4'd4,
        ST_TAP_INC   = 4'd5,
        ST_SETTLE    = 4'd6,
        ST_DONE      = 4'd7,
        ST_FAIL      = 4'd8
    } state_t;

    // Even words carry 0101..01, odd words its complement.
    function automatic logic [DATA_WIDTH-1:0] cal_pattern(input logic odd);
        logic [DATA_WIDTH-1:0] p;
        for (int b = 0; b < DATA_WIDTH / 2; b++) begin
            p[2*b +: 2] = 2'b01;
        end
        return odd ? ~p : p;
    endfunction

    state_t                state_r, state_s;
    logic [CW-1:0]         cnt_r, cnt_s;
    logic [KW-1:0]         idx_r, idx_s;
    logic [KW-1:0]         k_r, k_s;
    logic                  err_r, err_s;
    logic [TAP_WIDTH-1:0]  tap_r, tap_s;

    logic                  phy_dll_rst_r, phy_dll_rst_s;
    logic                  dly_rst_r, dly_rst_s;
    logic                  dly_inc_r, dly_inc_s;
    logic                  wr_en_r, wr_en_s;
    logic                  rd_en_r, rd_en_s;
    logic [ADDR_WIDTH-1:0] addr_r, addr_s;
    logic [DATA_WIDTH-1:0] wr_data_r, wr_data_s;
    logic                  phy_rdy_r, phy_rdy_s;
    logic                  cal_fail_r, cal_fail_s;

    // Next-state, counter and return-compare logic.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        idx_s   = idx_r;
        tap_s   = tap_r;
        k_s     = k_r;
        err_s   = err_r;

        // Returns count only while an attempt is live; surplus returns are dropped.
        if ((state_r == ST_READ || state_r == ST_CHECK) && cal.cal_rd_valid
            && (k_r < KW'(CAL_WORDS))) begin
            k_s = k_r + KW'(1);
            if (cal.cal_rd_data != cal_pattern(k_r[0])) begin
                err_s = 1'b1;
            end else begin
                err_s = err_r;
            end
        end else begin
            k_s   = k_r;
            err_s = err_r;
        end

        case (state_r)
            ST_RST: begin
                tap_s = '0;
                if (cnt_r == CW'(RST_CYCLES - 1)) begin
                    state_s = ST_LOCK_WAIT;
                    cnt_s   = '0;
                end else begin
                    cnt_s = cnt_r + CW'(1);
                end
            end
            ST_LOCK_WAIT: begin
                if (dll_locked) begin
                    state_s = ST_WRITE;
                    idx_s   = '0;
                    cnt_s   = '0;
                end else if (cnt_r == CW'(LOCK_TIMEOUT - 1)) begin
                    state_s = ST_FAIL;
                end else begin
                    cnt_s = cnt_r + CW'(1);
                end
            end
            ST_WRITE: begin
                if (idx_r == KW'(CAL_WORDS - 1)) begin
                    state_s = ST_READ;
                    idx_s   = '0;
                end else begin
                    idx_s = idx_r + KW'(1);
                end
            end
            ST_READ: begin
                if (idx_r == KW'(CAL_WORDS - 1)) begin
                    state_s = ST_CHECK;
                    cnt_s   = '0;
                end else begin
                    idx_s = idx_r + KW'(1);
                end
            end
            ST_CHECK: begin
                // Decision uses registered k/err, so it lands one cycle after the last return.
                if ((k_r == KW'(CAL_WORDS)) && !err_r) begin
                    state_s = ST_DONE;
                end else if ((k_r == KW'(CAL_WORDS)) || (cnt_r == CW'(RD_TIMEOUT - 1))) begin
                    if (tap_r == TAP_LAST) begin
                        state_s = ST_FAIL;
                    end else begin
                        state_s = ST_TAP_INC;
                        tap_s   = tap_r + TAP_WIDTH'(1);
                        k_s     = '0;
                        err_s   = 1'b0;
                    end
                end else begin
                    cnt_s = cnt_r + CW'(1);
                end
            end
            ST_TAP_INC: begin
                state_s = ST_SETTLE;
                cnt_s   = '0;
            end
            ST_SETTLE: begin
                if (cnt_r == CW'(SETTLE_CYCLES - 1)) begin
                    state_s = ST_READ;
                    idx_s   = '0;
                end else begin
                    cnt_s = cnt_r + CW'(1);
                end
            end
            ST_DONE: begin
                state_s = ST_DONE;
            end
            ST_FAIL: begin
                state_s = ST_FAIL;
            end
            default: begin
                state_s = ST_RST;
                cnt_s   = '0;
            end
        endcase
    end

    // Output decode from the next state so every output is a plain flop.
    always_comb begin
        phy_dll_rst_s = (state_s == ST_RST);
        dly_rst_s     = (state_s == ST_RST);
        dly_inc_s     = (state_s == ST_TAP_INC);
        wr_en_s       = (state_s == ST_WRITE);
        rd_en_s       = (state_s == ST_READ);
        phy_rdy_s     = (state_s == ST_DONE);
        cal_fail_s    = (state_s == ST_FAIL);
        if (state_s == ST_WRITE || state_s == ST_READ) begin
            addr_s = ADDR_WIDTH'(idx_s);
        end else begin
            addr_s = '0;
        end
        if (state_s == ST_WRITE) begin
            wr_data_s = cal_pattern(idx_s[0]);
        end else begin
            wr_data_s = '0;
        end
    end

    // State, counters and output registers; soft request behaves exactly like hard reset.
    always_ff @(posedge qdr_clk) begin
        if (!qdr_rst_n || qdr_reset) begin
            state_r       <= ST_RST;
            cnt_r         <= '0;
            idx_r         <= '0;
            k_r           <= '0;
            err_r         <= 1'b0;
            tap_r         <= '0;
            phy_dll_rst_r <= 1'b1;
            dly_rst_r     <= 1'b1;
            dly_inc_r     <= 1'b0;
            wr_en_r       <= 1'b0;
            rd_en_r       <= 1'b0;
            addr_r        <= '0;
            wr_data_r     <= '0;
            phy_rdy_r     <= 1'b0;
            cal_fail_r    <= 1'b0;
        end else begin
            state_r       <= state_s;
            cnt_r         <= cnt_s;
            idx_r         <= idx_s;
            k_r           <= k_s;
            err_r         <= err_s;
            tap_r         <= tap_s;
            phy_dll_rst_r <= phy_dll_rst_s;
            dly_rst_r     <= dly_rst_s;
            dly_inc_r     <= dly_inc_s;
            wr_en_r       <= wr_en_s;
            rd_en_r       <= rd_en_s;
            addr_r        <= addr_s;
            wr_data_r     <= wr_data_s;
            phy_rdy_r     <= phy_rdy_s;
            cal_fail_r    <= cal_fail_s;
        end
    end

    assign phy_dll_rst     = phy_dll_rst_r;
    assign dly_rst         = dly_rst_r;
    assign dly_inc         = dly_inc_r;
    assign cal_tap         = tap_r;
    assign phy_rdy         = phy_rdy_r;
    assign cal_fail        = cal_fail_r;
    assign cal.cal_wr_en   = wr_en_r;
    assign cal.cal_rd_en   = rd_en_r;
    assign cal.cal_addr    = addr_r;
    assign cal.cal_wr_data = wr_data_r;

endmodule
